rr_interval_tracker: RTL and testbench
======================================

// Module: rr_interval_tracker
// PURPOSE
//  Producer side of the RR-update interface. Counts sample strobes between accepted QRS detections.
//  Emits a one-cycle rru strobe with the measured rr_interval to the RR-average/threshold block.
//  Takes rrmiss back from that block and raises a search-back request when no beat arrives in time.
//  Sits between the QRS peak detector and the RR averaging stage, in the sample-rate (200 Hz) domain.
// PARAMETERS
//  DATA_WIDTH  16   width of rr_interval, rrmiss and the internal sample counter (signed)
//  PT200MS     40   refractory length in samples; detections at cnt < PT200MS are ignored
//  INIT_RR     200  rr_interval value after reset (1000 ms at 200 Hz)
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous reset, active-high
//  en           in   1           sample strobe; every counter/FSM update is qualified by en
//  qrs_det      in   1           QRS candidate from the peak detector; valid only when en=1
//  rrmiss       in   DATA_WIDTH  signed missed-beat limit from the RR-update block
//  rru          out  1           one-cycle strobe: rr_interval holds a new measurement
//  rr_interval  out  DATA_WIDTH  signed interval, in samples, between the last two accepted beats
//  searchback   out  1           one-cycle pulse on entry to MISSED
//  sb_active    out  1           high while state==MISSED
//  refractory   out  1           high while state==REFRACT
//  lost         out  1           one-cycle pulse: counter saturated with no beat, tracker re-armed
// BEHAVIOUR
//  Reset (rst=1 at posedge, en ignored):
//   - state=WAIT_FIRST, cnt=0, rr_interval=INIT_RR.
//   - rru, searchback, lost, sb_active and refractory are all 0.
//   - Reset mid-operation aborts any measurement in progress; no strobe is emitted.
//  Counter:
//   - cnt is unsigned-valued and saturates at CMAX = 2^(DATA_WIDTH-1)-1.
//   - On an accept, cnt loads 1; otherwise it increments on each en.
//   - A beat accepted at cnt=N gives an interval of N samples.
//  Cycles with en=0:
//   - cnt and state hold; qrs_det is ignored.
//   - rru, searchback and lost are 0.
//  Pulse timing: rru, searchback and lost are registered and are high for the clock after the causing en cycle.
//  FSM transitions (evaluated only when en=1):
//   - WAIT_FIRST: qrs_det -> accept, cnt=1, REFRACT, no rru (no interval exists yet).
//   - REFRACT:
//     - qrs_det is ignored.
//     - cnt increments.
//     - When the incremented cnt == PT200MS -> SEARCH.
//   - SEARCH:
//     - qrs_det -> rr_interval=cnt, rru=1, cnt=1, REFRACT.
//     - Otherwise, if signed cnt >= rrmiss -> searchback=1, MISSED, cnt increments.
//     - Otherwise cnt increments.
//   - MISSED:
//     - qrs_det -> same accept action as SEARCH, sb_active falls.
//     - Otherwise, if cnt == CMAX -> lost=1, cnt=0, WAIT_FIRST.
//  Precedence rules:
//   - qrs_det together with the rrmiss condition: the beat wins, no searchback.
//   - qrs_det with cnt == CMAX in MISSED: the beat wins, rr_interval = CMAX.
//  rrmiss handling:
//   - rrmiss is sampled live and compared as signed.
//   - If rrmiss <= PT200MS, searchback fires on the first SEARCH sample with no beat.
//  Output rules:
//   - rr_interval changes only on accept (or reset) and is held between accepts.
//   - rr_interval is always in the range [PT200MS, CMAX].
//   - rru is never high for two consecutive clocks.
// TESTING
//  1. en=1 every clk, qrs_det at samples 10, 210, 410 -> no rru at 10; rru with rr_interval=200 after 210 and after 410.
//  2. Beats at 0 and 150 with an extra qrs_det at 30 -> the 30 is ignored (refractory=1); rr_interval=150.
//  3. rrmiss=332, beat at 0, next qrs_det at 400 -> searchback pulse at cnt=332, sb_active high until the accept; rr_interval=400.
//  4. rrmiss=332, qrs_det exactly at cnt=332 -> rru with rr_interval=332, searchback stays 0.
//  5. en asserted every 3rd clk, beats 100 samples apart -> rr_interval=100; rru, searchback and lost are each 1 clk wide.
//  6. DATA_WIDTH=10, no beats -> lost at cnt=511 and WAIT_FIRST; rst=1 in REFRACT -> all outputs at reset values next clk, rr_interval=200.

Source files
------------

// File: rtl/rr_interval_tracker.sv
// RR interval tracker: measures samples between accepted QRS beats,
// strobes each new interval and requests search-back on missed beats.
module rr_interval_tracker #(
   parameter int DATA_WIDTH = 16,
   parameter int PT200MS    = 40,
   parameter int INIT_RR    = 200
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         qrs_det,
   input  logic signed [DATA_WIDTH-1:0] rrmiss,
   output logic                         rru,
   output logic signed [DATA_WIDTH-1:0] rr_interval,
   output logic                         searchback,
   output logic                         sb_active,
   output logic                         refractory,
   output logic                         lost
);

   localparam logic [DATA_WIDTH-1:0] CMAX =
      {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] PT = DATA_WIDTH'(PT200MS);
   localparam logic [DATA_WIDTH-1:0] RR0 = DATA_WIDTH'(INIT_RR);
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   typedef enum logic [1:0] {
      WAIT_FIRST,
      REFRACT,
      SEARCH,
      MISSED
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [DATA_WIDTH-1:0]   rr_q, rr_d;
   logic                    rru_d, sb_d, lost_d;

   assign cnt_inc     = (cnt_q == CMAX) ? CMAX : cnt_q + ONE;
   assign rr_interval = rr_q;
   assign sb_active   = (state_q == MISSED);
   assign refractory  = (state_q == REFRACT);

   // next-state, counter and strobe decode; only en cycles advance
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      rru_d   = 1'b0;
      sb_d    = 1'b0;
      lost_d  = 1'b0;
      if (en) begin
         cnt_d = cnt_inc;
         unique case (state_q)
            WAIT_FIRST: begin
               if (qrs_det) begin
                  cnt_d   = ONE;
                  state_d = REFRACT;
               end
            end
            REFRACT: begin
               if (cnt_inc == PT)
                  state_d = SEARCH;
            end
            SEARCH: begin
               if (qrs_det) begin
                  rr_d    = cnt_q;
                  rru_d   = 1'b1;
                  cnt_d   = ONE;
                  state_d = REFRACT;
               end else if ($signed(cnt_q) >= rrmiss) begin
                  sb_d    = 1'b1;
                  state_d = MISSED;
               end
            end
            MISSED: begin
               if (qrs_det) begin
                  rr_d    = cnt_q;
                  rru_d   = 1'b1;
                  cnt_d   = ONE;
                  state_d = REFRACT;
               end else if (cnt_q == CMAX) begin
                  lost_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = WAIT_FIRST;
               end
            end
            default: state_d = WAIT_FIRST;
         endcase
      end
   end

   // state, counter, held interval and registered one-cycle strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT_FIRST;
         cnt_q      <= '0;
         rr_q       <= RR0;
         rru        <= 1'b0;
         searchback <= 1'b0;
         lost       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rr_q       <= rr_d;
         rru        <= rru_d;
         searchback <= sb_d;
         lost       <= lost_d;
      end
   end

endmodule

// File: tb/tb_rr_interval_tracker.sv
// Scoreboard bench for rr_interval_tracker (DATA_WIDTH=10, CMAX=511).
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_rr_interval_tracker;

   localparam int DW = 10;
   localparam logic [2:0] K_RRU  = 3'b001;
   localparam logic [2:0] K_SB   = 3'b010;
   localparam logic [2:0] K_LOST = 3'b100;

   typedef struct {
      logic [2:0] kind;
      int         val;
      int         cyc;
   } ev_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic                 qrs_det;
   logic signed [DW-1:0] rrmiss;
   logic                 rru;
   logic signed [DW-1:0] rr_interval;
   logic                 searchback;
   logic                 sb_active;
   logic                 refractory;
   logic                 lost;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   ev_t  sb_q[$];

   rr_interval_tracker #(
      .DATA_WIDTH(DW),
      .PT200MS   (40),
      .INIT_RR   (200)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .qrs_det    (qrs_det),
      .rrmiss     (rrmiss),
      .rru        (rru),
      .rr_interval(rr_interval),
      .searchback (searchback),
      .sb_active  (sb_active),
      .refractory (refractory),
      .lost       (lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      logic [2:0] k;
      ev_t        e;
      k = {lost, searchback, rru};
      if (k != 3'b000) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected strobe: got kind=%b rr=%0d cyc=%0d, required none",
                     k, rr_interval, cyc);
         end else begin
            e = sb_q.pop_front();
            if (k != e.kind || cyc != e.cyc ||
                (e.kind == K_RRU && int'(rr_interval) != e.val)) begin
               bad++;
               $display("FAIL strobe: got kind=%b rr=%0d cyc=%0d, required kind=%b rr=%0d cyc=%0d",
                        k, rr_interval, cyc, e.kind, e.val, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic smp(input logic q);
      en      = 1'b1;
      qrs_det = q;
      @(posedge clk);
      #1;
      en      = 1'b0;
      qrs_det = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [2:0] k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      e.cyc  = cyc;
      sb_q.push_back(e);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      en      = 1'b1;
      qrs_det = 1'b1;
      rrmiss  = 10'sd500;
      idle(2);
      chk("reset rr_interval", int'(rr_interval), 200);
      chk("reset rru", int'(rru), 0);
      chk("reset searchback", int'(searchback), 0);
      chk("reset lost", int'(lost), 0);
      chk("reset sb_active", int'(sb_active), 0);
      chk("reset refractory", int'(refractory), 0);
      rst     = 1'b0;
      en      = 1'b0;
      qrs_det = 1'b0;
      idle(1);

      // 1: beats at 10, 210, 410
      for (int s = 0; s <= 410; s++) begin
         smp(s == 10 || s == 210 || s == 410);
         if (s == 210 || s == 410) push(K_RRU, 200);
         if (s == 10) chk("t1 refractory", int'(refractory), 1);
      end

      // 2: extra detection inside refractory ignored
      for (int s = 1; s <= 150; s++) begin
         if (s == 30) chk("t2 refractory", int'(refractory), 1);
         smp(s == 30 || s == 150);
         if (s == 150) push(K_RRU, 150);
      end

      // 3: missed beat, search-back, late beat
      rrmiss = 10'sd332;
      for (int s = 1; s <= 400; s++) begin
         smp(s == 400);
         if (s == 332) push(K_SB, 0);
         if (s == 331) chk("t3 sb_active pre", int'(sb_active), 0);
         if (s == 399) chk("t3 sb_active", int'(sb_active), 1);
         if (s == 400) push(K_RRU, 400);
      end
      chk("t3 sb_active post", int'(sb_active), 0);

      // 4: beat exactly at rrmiss wins
      for (int s = 1; s <= 332; s++) begin
         smp(s == 332);
         if (s == 332) push(K_RRU, 332);
      end

      // 5: en every third clock
      rrmiss = 10'sd500;
      for (int s = 1; s <= 100; s++) begin
         smp(s == 100);
         if (s == 100) push(K_RRU, 100);
         idle(2);
      end
      rrmiss = 10'sd60;
      for (int s = 1; s <= 100; s++) begin
         smp(s == 100);
         if (s == 60) push(K_SB, 0);
         if (s == 100) push(K_RRU, 100);
         idle(2);
      end

      // 6: saturation without a beat -> lost
      rrmiss = 10'sd300;
      for (int s = 1; s <= 511; s++) begin
         smp(1'b0);
         if (s == 300) push(K_SB, 0);
         if (s == 511) push(K_LOST, 0);
         idle(2);
      end
      chk("t6 sb_active", int'(sb_active), 0);
      chk("t6 refractory", int'(refractory), 0);
      chk("t6 rr held", int'(rr_interval), 100);

      // beat at CMAX in MISSED wins
      smp(1'b1);
      for (int s = 1; s <= 511; s++) begin
         smp(s == 511);
         if (s == 300) push(K_SB, 0);
         if (s == 511) push(K_RRU, 511);
      end

      // reset while refractory
      for (int s = 0; s < 5; s++) smp(1'b0);
      chk("pre-rst refractory", int'(refractory), 1);
      rst     = 1'b1;
      en      = 1'b1;
      qrs_det = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      en      = 1'b0;
      qrs_det = 1'b0;
      chk("rst rr_interval", int'(rr_interval), 200);
      chk("rst refractory", int'(refractory), 0);
      chk("rst sb_active", int'(sb_active), 0);
      chk("rst rru", int'(rru), 0);

      // rrmiss below refractory length
      rrmiss = 10'sd20;
      smp(1'b1);
      for (int s = 1; s <= 50; s++) begin
         smp(s == 50);
         if (s == 40) push(K_SB, 0);
         if (s == 50) push(K_RRU, 50);
      end

      idle(5);
      chk("scoreboard drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
